// File: rtl/spu_preloader_if.sv
// Host-to-preloader word stream: valid/ready handshake carrying headers and payload.
interface spu_preloader_if;
  logic        host_valid;
  logic [0:31] host_data;
  logic        host_ready;

  modport master (output host_valid, output host_data, input host_ready);
  modport slave  (input host_valid, input host_data, output host_ready);
endinterface

// File: rtl/spu_preloader.sv
// SPU preloader: parses a host record stream and issues instruction, local-store
// and register-file writes while holding the core; async active-low reset.
module spu_preloader (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  spu_preloader_if.slave host,
  output logic         load_en,
  output logic [0:31]  instruction_in,
  output logic         preload_LS_en,
  output logic [0:10]  preload_LS_addr,
  output logic [0:127] preload_LS_data,
  output logic         preload_en,
  output logic [0:6]   preload_addr,
  output logic [0:127] preload_values,
  output logic         core_hold,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, HDR, INSTR, LS, RF, DONE} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   rem_reg;
  logic [1:0]    word_idx_reg;
  logic [0:10]   ls_idx_reg;
  logic [0:6]    rf_idx_reg;
  logic          load_en_reg, ls_en_reg, rf_en_reg;
  logic [0:31]   instr_reg;
  logic [0:10]   ls_addr_reg;
  logic [0:6]    rf_addr_reg;
  logic [0:127]  ls_data_reg, rf_data_reg;

  logic          accept;
  logic [1:0]    hdr_kind;
  logic [15:0]   hdr_count;
  logic          last_unit;
  logic          word_last;
  logic          packing;

  assign accept    = host.host_valid && host.host_ready;
  assign hdr_kind  = host.host_data[0:1];
  assign hdr_count = host.host_data[16:31];
  assign last_unit = (rem_reg == 16'd1);
  assign word_last = (word_idx_reg == 2'd3);
  assign packing   = (state_reg == LS) || (state_reg == RF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = HDR;
      HDR: begin
        if (accept) begin
          if (hdr_kind == 2'b11) state_next = DONE;
          else if (hdr_count != 16'd0) begin
            case (hdr_kind)
              2'b00:   state_next = INSTR;
              2'b01:   state_next = LS;
              default: state_next = RF;
            endcase
          end
        end
      end
      INSTR:   if (accept && last_unit) state_next = HDR;
      LS, RF:  if (accept && word_last && last_unit) state_next = HDR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    host.host_ready = 1'b0;
    core_hold       = 1'b1;
    done            = 1'b0;
    case (state_reg)
      HDR, INSTR, LS, RF: host.host_ready = 1'b1;
      DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // The first three words of a quadword wait in per-lane registers; the fourth
  // goes straight into the output quadword on its acceptance edge.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [0:31] word_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          word_reg <= '0;
        else if (accept && packing && (word_idx_reg == 2'(gi)))
          word_reg <= host.host_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_reg      <= '0;
      word_idx_reg <= '0;
      ls_idx_reg   <= '0;
      rf_idx_reg   <= '0;
      load_en_reg  <= 1'b0;
      ls_en_reg    <= 1'b0;
      rf_en_reg    <= 1'b0;
      instr_reg    <= '0;
      ls_addr_reg  <= '0;
      rf_addr_reg  <= '0;
      ls_data_reg  <= '0;
      rf_data_reg  <= '0;
    end else begin
      load_en_reg <= 1'b0;
      ls_en_reg   <= 1'b0;
      rf_en_reg   <= 1'b0;
      if (accept) begin
        case (state_reg)
          HDR: begin
            rem_reg      <= hdr_count;
            ls_idx_reg   <= host.host_data[2:12];
            rf_idx_reg   <= host.host_data[6:12];
            word_idx_reg <= 2'd0;
          end
          INSTR: begin
            load_en_reg <= 1'b1;
            instr_reg   <= host.host_data;
            rem_reg     <= rem_reg - 16'd1;
          end
          LS, RF: begin
            word_idx_reg <= word_idx_reg + 2'd1;
            if (word_last) begin
              rem_reg <= rem_reg - 16'd1;
              if (state_reg == LS) begin
                ls_en_reg   <= 1'b1;
                ls_addr_reg <= ls_idx_reg;
                ls_data_reg <= {g_lane[0].word_reg, g_lane[1].word_reg,
                                g_lane[2].word_reg, host.host_data};
                ls_idx_reg  <= ls_idx_reg + 11'd1;
              end else begin
                rf_en_reg   <= 1'b1;
                rf_addr_reg <= rf_idx_reg;
                rf_data_reg <= {g_lane[0].word_reg, g_lane[1].word_reg,
                                g_lane[2].word_reg, host.host_data};
                rf_idx_reg  <= rf_idx_reg + 7'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign load_en         = load_en_reg;
  assign instruction_in  = instr_reg;
  assign preload_LS_en   = ls_en_reg;
  assign preload_LS_addr = ls_addr_reg;
  assign preload_LS_data = ls_data_reg;
  assign preload_en      = rf_en_reg;
  assign preload_addr    = rf_addr_reg;
  assign preload_values  = rf_data_reg;

endmodule

// File: doc/spu_preloader.md
SPU_PRELOADER -- requirements
Module: spu_preloader

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous reset, active-low; asserted (0) forces reset state immediately, released synchronously to clk.
REQ-003 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-004 SHALL have port host_valid  input  1  host word available.
REQ-005 SHALL have port host_data  input  [0:31]  host word (header or payload).
REQ-006 SHALL have port host_ready  output  1  preloader accepts word; transfer occurs when host_valid && host_ready at a rising edge.
REQ-007 SHALL have port load_en  output  1  instruction write strobe toward fetch stage.
REQ-008 SHALL have port instruction_in  output  [0:31]  instruction word, valid with load_en.
REQ-009 SHALL have port preload_LS_en  output  1  local-store quadword write strobe.
REQ-010 SHALL have port preload_LS_addr  output  [0:10]  local-store quadword index.
REQ-011 SHALL have port preload_LS_data  output  [0:127]  local-store quadword.
REQ-012 SHALL have port preload_en  output  1  register-file write strobe.
REQ-013 SHALL have port preload_addr  output  [0:6]  register index.
REQ-014 SHALL have port preload_values  output  [0:127]  register value.
REQ-015 SHALL have port core_hold  output  1  holds the SPU core in reset/stall while loading.
REQ-016 SHALL have port done  output  1  session complete, level.

Function
REQ-017 SHALL implement FSM states IDLE, HDR, INSTR, LS, RF, DONE.
REQ-018 SHALL drive host_ready=1 only in HDR, INSTR, LS, RF.
REQ-019 SHALL, in IDLE or DONE, move to HDR on start=1, set core_hold=1, clear done; start in any other state is ignored.
REQ-020 SHALL decode each accepted header word as: kind=bits[0:1], base=bits[2:12], count=bits[16:31].
REQ-021 SHALL, on kind 00, enter INSTR; 01 enter LS with LS index=base; 10 enter RF with register index=base[4:10]; 11 enter DONE.
REQ-022 SHALL treat count=0 for kinds 00/01/10 as an empty record: remain in HDR, produce no write.
REQ-023 SHALL, in INSTR, for each accepted word assert load_en for exactly one cycle, the cycle after acceptance, with instruction_in=that word; return to HDR after count words.
REQ-024 SHALL, in LS and RF, pack four accepted words into one quadword, first word into bits[0:31], fourth into bits[96:127]; count is in quadwords.
REQ-025 SHALL assert preload_LS_en (LS) or preload_en (RF) for one cycle, the cycle after the fourth word is accepted, with address and data stable that cycle.
REQ-026 SHALL increment the LS index after each quadword, wrapping 2047->0, and the register index, wrapping 127->0.
REQ-027 SHALL return to HDR after the count-th quadword; partial quadwords never occur inside a record.
REQ-028 SHALL tolerate host_valid gaps of any length in any state without losing or duplicating words.
REQ-029 SHALL, on entering DONE, set done=1 and core_hold=0 in the same cycle; done holds until next start.
REQ-030 SHALL never assert more than one of load_en, preload_LS_en, preload_en in a cycle.
REQ-031 SHALL ignore host_data when host_ready=0.

Reset
REQ-032 SHALL on rst=0 enter IDLE and clear host_ready, load_en, preload_LS_en, preload_en, done, all addresses, data registers, word/record counters; core_hold=1.
REQ-033 SHALL abort any session on reset mid-record; partially packed quadword is discarded, no write strobe is issued.

Verification
REQ-034 SHALL pass: start, header 0x00000003, words A,B,C back-to-back, header 0xC0000000 -> three load_en pulses with A,B,C in order; done=1, core_hold=0.
REQ-035 SHALL pass: header kind 01 base 2047 count 2, eight words 0..7 -> LS writes at 2047 data {0,1,2,3} then at 0 data {4,5,6,7}.
REQ-036 SHALL pass: header kind 10 base 127 count 2 -> preload_en at addr 127 then 0.
REQ-037 SHALL pass: header count 0 followed by kind 11 -> no strobes, done=1.
REQ-038 SHALL pass: random host_valid gaps during LS record -> identical writes to gap-free run.
REQ-039 SHALL pass: rst=0 after two LS words -> no strobe, all outputs at reset values, core_hold=1.
